// File: rtl/cnu_stream.sv
// Streaming min-sum check node unit: accumulates one v2c message per beat for a
// check row (min/min2/min_idx/sign parity), then replays the row's c2v messages
// in arrival order with run-time selectable scaling (3/4 normalized, offset, none).
module cnu_stream #(
    parameter int DMAX   = 8,
    parameter int data_w = 8,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [data_w-1:0] in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [data_w-1:0] out_r
);

    localparam int CW = $clog2(DMAX + 1);
    localparam int MW = data_w - 1;
    localparam logic [MW-1:0] MAXMAG   = '1;
    localparam logic [MW-1:0] OFF      = MW'(OFFSET);
    localparam logic [CW-1:0] LAST_IDX = CW'(DMAX - 1);

    typedef enum logic { ACC,  FULL } acc_state_t;
    typedef enum logic { IDLE, SEND } out_state_t;

    acc_state_t acc_state, acc_next;
    out_state_t out_state, out_next;

    // accumulator bank
    logic [CW-1:0]   cnt;
    logic [MW-1:0]   amin, amin2;
    logic [CW-1:0]   amin_idx;
    logic            aparity;
    logic [DMAX-1:0] asgn;

    // output bank
    logic [CW-1:0]   k;
    logic [CW-1:0]   bdeg;
    logic [MW-1:0]   bmin, bmin2;
    logic [CW-1:0]   bidx;
    logic            bpar;
    logic [DMAX-1:0] bsgn;
    logic [1:0]      bmode;

    logic              in_beat, out_beat, final_beat, row_end, transfer;
    logic              q_msb;
    logic [data_w-1:0] q_neg;
    logic [MW-1:0]     q_mag;
    logic [MW-1:0]     sel_m;
    logic [data_w:0]   norm3;
    logic [data_w-1:0] s_val;
    logic              sgn_k;

    assign in_ready  = en && !rst && (acc_state == ACC);
    assign out_valid = en && !rst && (out_state == SEND);

    assign in_beat    = en && in_valid && in_ready;
    assign out_beat   = en && out_valid && out_ready;
    assign final_beat = out_beat && out_last;
    assign row_end    = in_beat && (in_last || (cnt == LAST_IDX));
    assign transfer   = en && (acc_state == FULL) && ((out_state == IDLE) || final_beat);

    // Saturated magnitude of the incoming message (most negative value maps to MAXMAG)
    always_comb begin
        q_msb = in_q[data_w-1];
        q_neg = -in_q;
        if (!q_msb)
            q_mag = in_q[MW-1:0];
        else if (q_neg[data_w-1])
            q_mag = MAXMAG;
        else
            q_mag = q_neg[MW-1:0];
    end

    // Next-state logic for the accumulator and output FSMs
    always_comb begin
        acc_next = acc_state;
        out_next = out_state;
        if (row_end)
            acc_next = FULL;
        if (transfer)
            acc_next = ACC;
        if (transfer)
            out_next = SEND;
        else if (final_beat)
            out_next = IDLE;
    end

    // State registers and both data banks
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_state <= ACC;
            out_state <= IDLE;
            cnt       <= '0;
            amin      <= MAXMAG;
            amin2     <= MAXMAG;
            amin_idx  <= '0;
            aparity   <= 1'b0;
            asgn      <= '0;
            k         <= '0;
            bdeg      <= '0;
            bmin      <= '0;
            bmin2     <= '0;
            bidx      <= '0;
            bpar      <= 1'b0;
            bsgn      <= '0;
            bmode     <= '0;
        end else begin
            acc_state <= acc_next;
            out_state <= out_next;
            // transfer only happens in FULL and input beats only in ACC, so the branches are exclusive
            if (transfer) begin
                bdeg     <= cnt;
                bmin     <= amin;
                bmin2    <= amin2;
                bidx     <= amin_idx;
                bpar     <= aparity;
                bsgn     <= asgn;
                bmode    <= mode;
                k        <= '0;
                cnt      <= '0;
                amin     <= MAXMAG;
                amin2    <= MAXMAG;
                amin_idx <= '0;
                aparity  <= 1'b0;
                asgn     <= '0;
            end else if (in_beat) begin
                if (q_mag < amin) begin
                    amin2    <= amin;
                    amin     <= q_mag;
                    amin_idx <= cnt;
                end else if (q_mag < amin2) begin
                    amin2 <= q_mag;
                end
                for (int unsigned i = 0; i < DMAX; i++)
                    if (cnt == CW'(i))
                        asgn[i] <= q_msb;
                aparity <= aparity ^ q_msb;
                cnt     <= cnt + CW'(1);
            end
            if (out_beat && !final_beat)
                k <= k + CW'(1);
        end
    end

    // c2v message for the current output index: select magnitude, scale, apply sign
    always_comb begin
        sel_m = (k == bidx) ? bmin2 : bmin;
        norm3 = {1'b0, sel_m, 1'b0} + {2'b00, sel_m};
        sgn_k = 1'b0;
        for (int unsigned i = 0; i < DMAX; i++)
            if (k == CW'(i))
                sgn_k = bsgn[i];
        case (bmode)
            2'b00:   s_val = data_w'(norm3 >> 2);
            2'b01:   s_val = (sel_m > OFF) ? {1'b0, sel_m - OFF} : '0;
            default: s_val = {1'b0, sel_m};
        endcase
        if (out_state == SEND) begin
            out_r    = (bpar ^ sgn_k) ? -s_val : s_val;
            out_last = (k == bdeg - CW'(1));
        end else begin
            out_r    = '0;
            out_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_cnu_stream.sv
// Bench for cnu_stream: directed rows with literal expectations plus randomized
// traffic (random en / out_ready / gaps) checked against a min-over-others model.
module tb_cnu_stream;

    localparam int DMAX   = 8;
    localparam int DW     = 8;
    localparam int OFFSET = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_q = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic [DW-1:0] out_r;

    cnu_stream #(.DMAX(DMAX), .data_w(DW), .OFFSET(OFFSET)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_r(out_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] r;
        logic          last;
    } exp_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] cur_row[$];
    exp_t          exp_q[$];
    logic [DW-1:0] obs_q[$];
    logic          obs_last[$];
    int            ref_v[$];
    logic [DW-1:0] row_v[$];
    logic          rnd_on = 1'b0;
    logic          hold = 1'b0;
    logic [DW-1:0] h_r;
    logic          h_last;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int mag_of(input logic [DW-1:0] q);
        int v;
        v = int'($signed(q));
        if (v < 0) v = -v;
        return (v > 127) ? 127 : v;
    endfunction

    // Reference: each output magnitude is the smallest magnitude among the other
    // messages of the row, its sign the XOR of the other messages' signs.
    task automatic finish_row();
        int n, m, s, r;
        logic sg;
        logic [DW-1:0] v;
        exp_t e;
        n = cur_row.size();
        for (int kk = 0; kk < n; kk++) begin
            m = 127;
            sg = 1'b0;
            for (int j = 0; j < n; j++) begin
                if (j != kk) begin
                    v = cur_row[j];
                    if (mag_of(v) < m) m = mag_of(v);
                    sg = sg ^ v[DW-1];
                end
            end
            case (mode)
                2'b00:   s = (3 * m) / 4;
                2'b01:   s = (m > OFFSET) ? m - OFFSET : 0;
                default: s = m;
            endcase
            r = sg ? -s : s;
            e.r = DW'(r);
            e.last = (kk == n - 1);
            exp_q.push_back(e);
        end
        cur_row.delete();
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cur_row.delete();
            exp_q.delete();
            hold = 1'b0;
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
        end else begin
            if (!en) begin
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_out_valid", int'(out_valid), 0);
            end
            if (en && hold) begin
                check("stable_valid", int'(out_valid), 1);
                check("stable_r", int'($signed(out_r)), int'($signed(h_r)));
                check("stable_last", int'(out_last), int'(h_last));
            end
            if (en) begin
                hold   = out_valid && !out_ready;
                h_r    = out_r;
                h_last = out_last;
            end
            if (en && in_valid && in_ready) begin
                cur_row.push_back(in_q);
                if (in_last || cur_row.size() == DMAX) finish_row();
            end
            if (en && out_valid && out_ready) begin
                obs_q.push_back(out_r);
                obs_last.push_back(out_last);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_r", int'($signed(out_r)), int'($signed(e.r)));
                    check("out_last", int'(out_last), int'(e.last));
                end
            end
        end
    end

    // Random stall / backpressure generator, active only in the random phase
    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] q, input logic last);
        int unsigned guard = 0;
        logic took = 1'b0;
        in_valid = 1'b1;
        in_q     = q;
        in_last  = last;
        do begin
            @(negedge clk);
            took = en && in_ready;
            tick();
            guard++;
        end while (!took && guard < 500);
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept expected accept within 500 cycles");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_row(input logic no_last);
        for (int i = 0; i < row_v.size(); i++)
            send_beat(row_v[i], (i == row_v.size() - 1) && !no_last);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || cur_row.size() != 0) && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic compare_obs(input string name);
        check({name, "_count"}, obs_q.size(), ref_v.size());
        for (int i = 0; i < ref_v.size() && i < obs_q.size(); i++) begin
            check({name, "_val"}, int'($signed(obs_q[i])), ref_v[i]);
            check({name, "_last"}, int'(obs_last[i]), int'(i == ref_v.size() - 1));
        end
        obs_q.delete();
        obs_last.delete();
    endtask

    initial begin
        int deg;
        logic forced;
        logic [DW-1:0] v;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_out_r", int'(out_r), 0);
        rst = 1'b0;
        tick();
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid2", int'(out_valid), 0);

        // T1: normalized row with latency check
        mode = 2'b00;
        row_v = '{8'd5, 8'hFD, 8'd7, 8'hFE};
        send_row(1'b0);
        check("lat_not_yet", int'(out_valid), 0);
        check("lat_full_in_ready", int'(in_ready), 0);
        tick();
        check("lat_valid", int'(out_valid), 1);
        drain();
        ref_v = '{1, -1, 1, -2};
        compare_obs("t1");

        // T2: offset and unscaled
        mode = 2'b01;
        send_row(1'b0);
        drain();
        ref_v = '{1, -1, 1, -2};
        compare_obs("t2_off");
        mode = 2'b10;
        send_row(1'b0);
        drain();
        ref_v = '{2, -2, 2, -3};
        compare_obs("t2_raw");

        // T3: tie keeps first min_idx; saturation of the most negative value
        mode = 2'b00;
        row_v = '{8'd4, 8'd4, 8'hFC};
        send_row(1'b0);
        drain();
        ref_v = '{-3, -3, 3};
        compare_obs("t3_tie");
        mode = 2'b10;
        row_v = '{8'h80, 8'd1};
        send_row(1'b0);
        drain();
        obs_q.delete();
        obs_last.delete();

        // T4: backpressure with a second row waiting in FULL
        mode = 2'b00;
        out_ready = 1'b0;
        row_v = '{8'd9, 8'hF0, 8'd3};
        send_row(1'b0);
        row_v = '{8'hFA, 8'd2, 8'd11};
        send_row(1'b0);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        repeat (5) tick();
        check("bp_still_full", int'(in_ready), 0);
        out_ready = 1'b1;
        drain();
        check("bp_count", obs_q.size(), 6);
        obs_q.delete();
        obs_last.delete();

        // T5: forced row end at DMAX and a degree-1 row
        row_v = '{8'd10, 8'd20, 8'hE0, 8'd7, 8'd50, 8'hC0, 8'd8, 8'd90};
        send_row(1'b1);
        drain();
        check("forced_count", obs_q.size(), 8);
        if (obs_last.size() == 8) begin
            check("forced_last7", int'(obs_last[7]), 1);
            check("forced_last6", int'(obs_last[6]), 0);
        end
        obs_q.delete();
        obs_last.delete();
        mode = 2'b10;
        row_v = '{8'hFA};
        send_row(1'b0);
        drain();
        obs_q.delete();
        obs_last.delete();

        // T6: reset after two beats, then a clean row
        mode = 2'b00;
        send_beat(8'd33, 1'b0);
        send_beat(8'hE1, 1'b0);
        rst = 1'b1;
        tick();
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_r", int'(out_r), 0);
        rst = 1'b0;
        tick();
        row_v = '{8'd5, 8'hFD, 8'd7, 8'hFE};
        send_row(1'b0);
        drain();
        ref_v = '{1, -1, 1, -2};
        compare_obs("t6_clean");

        // T6: reset mid-output
        out_ready = 1'b0;
        send_row(1'b0);
        tick();
        check("rst_out_pre", int'(out_valid), 1);
        rst = 1'b1;
        tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_r", int'(out_r), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst_out_after", int'(out_valid), 0);
        check("rst_in_after", int'(in_ready), 1);
        obs_q.delete();
        obs_last.delete();

        // T6: en=0 mid-row freezes state
        send_beat(8'd5, 1'b0);
        send_beat(8'hFD, 1'b0);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        send_beat(8'd7, 1'b0);
        send_beat(8'hFE, 1'b1);
        drain();
        ref_v = '{1, -1, 1, -2};
        compare_obs("t6_stall");

        // randomized traffic
        rnd_on = 1'b1;
        for (int b = 0; b < 8; b++) begin
            mode = 2'($urandom_range(0, 3));
            for (int r = 0; r < 25; r++) begin
                deg = $urandom_range(1, DMAX);
                forced = (deg == DMAX) && ($urandom_range(0, 1) == 1);
                for (int i = 0; i < deg; i++) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
                    v = DW'($urandom_range(0, 255));
                    if ($urandom_range(0, 9) == 0) v = 8'h80;
                    send_beat(v, (i == deg - 1) && !forced);
                end
            end
            drain();
        end
        rnd_on = 1'b0;
        tick();
        en = 1'b1;
        out_ready = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
